// File: rtl/irq_ctrl.sv
// Sequential interrupt controller for the factorial accelerators' Done lines.
// Edge-detects Done into sticky pending bits and runs an irq/iack/EOI handshake with the core.
module irq_ctrl #(
    parameter int          NSRC       = 4,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
    parameter logic [31:0] VEC_STRIDE = 32'h0000_0010,
    localparam int         IDW        = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] done,
    input  logic            we,
    input  logic [1:0]      a,
    input  logic [31:0]     wd,
    output logic [31:0]     rd,
    input  logic            iack,
    output logic            irq,
    output logic [31:0]     isr_addr,
    output logic [IDW-1:0]  src_id
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t          state_r;
    logic [NSRC-1:0] done_q_r;
    logic [NSRC-1:0] pend_r;
    logic [NSRC-1:0] mask_r;
    logic [IDW-1:0]  id_r;
    logic [15:0]     count_r;
    logic            irq_r;
    logic [31:0]     isr_addr_r;
    logic [IDW-1:0]  src_id_r;

    logic [NSRC-1:0] rise_s;
    logic [NSRC-1:0] eligible_s;
    logic [NSRC-1:0] w1c_s;
    logic [NSRC-1:0] ack_clr_s;
    logic [NSRC-1:0] pend_next_s;
    logic [IDW-1:0]  sel_id_s;
    logic            ack_s;
    logic            eoi_s;
    logic            mask_we_s;
    logic            count_clr_s;
    logic            wd_unused_s;

    // Source 0 has the highest priority, so the lowest set index wins.
    function automatic logic [IDW-1:0] lowest_index(input logic [NSRC-1:0] v);
        logic [IDW-1:0] idx;
        idx = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = IDW'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [31:0] vec_addr(input logic [IDW-1:0] idx);
        return VEC_BASE + (VEC_STRIDE * 32'(idx));
    endfunction

    assign wd_unused_s = ^wd[31:NSRC];
    assign ack_s       = (state_r == ST_REQ) && iack;
    assign eoi_s       = we && (a == 2'd2);
    assign mask_we_s   = we && (a == 2'd1);
    assign count_clr_s = we && (a == 2'd3);

    // Pending-bit next state: a fresh rise always beats W1C and the iack clear.
    always_comb begin
        rise_s     = done & ~done_q_r;
        eligible_s = pend_r & mask_r;
        sel_id_s   = lowest_index(eligible_s);
        ack_clr_s  = '0;
        if (we && (a == 2'd0)) begin
            w1c_s = wd[NSRC-1:0];
        end else begin
            w1c_s = '0;
        end
        if (ack_s) begin
            ack_clr_s[id_r] = 1'b1;
        end else begin
            ack_clr_s = '0;
        end
        pend_next_s = (pend_r & ~(w1c_s | ack_clr_s)) | rise_s;
    end

    // Register read mux.
    always_comb begin
        rd = 32'h0000_0000;
        case (a)
            2'd0: rd[NSRC-1:0] = pend_r;
            2'd1: rd[NSRC-1:0] = mask_r;
            2'd2: begin
                rd[31]      = (state_r == ST_SERVICE);
                rd[IDW-1:0] = id_r;
            end
            2'd3: rd[15:0] = count_r;
            default: rd = 32'h0000_0000;
        endcase
    end

    // Done edge capture, pending and mask registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_q_r <= '0;
            pend_r   <= '0;
            mask_r   <= '0;
        end else begin
            done_q_r <= done;
            pend_r   <= pend_next_s;
            if (mask_we_s) begin
                mask_r <= wd[NSRC-1:0];
            end
        end
    end

    // Handshake FSM with registered irq/vector outputs and the iack counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            id_r       <= '0;
            count_r    <= 16'h0000;
            irq_r      <= 1'b0;
            isr_addr_r <= 32'h0000_0000;
            src_id_r   <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (|eligible_s) begin
                        state_r    <= ST_REQ;
                        id_r       <= sel_id_s;
                        irq_r      <= 1'b1;
                        isr_addr_r <= vec_addr(sel_id_s);
                        src_id_r   <= sel_id_s;
                    end else begin
                        irq_r      <= 1'b0;
                        isr_addr_r <= 32'h0000_0000;
                        src_id_r   <= '0;
                    end
                end
                ST_REQ: begin
                    if (iack) begin
                        state_r <= ST_SERVICE;
                        irq_r   <= 1'b0;
                        if (count_r != 16'hFFFF) begin
                            count_r <= count_r + 16'd1;
                        end
                    end
                end
                ST_SERVICE: begin
                    if (eoi_s) begin
                        state_r    <= ST_IDLE;
                        isr_addr_r <= 32'h0000_0000;
                        src_id_r   <= '0;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    irq_r      <= 1'b0;
                    isr_addr_r <= 32'h0000_0000;
                    src_id_r   <= '0;
                end
            endcase
            if (count_clr_s) begin
                count_r <= 16'h0000;
            end
        end
    end

    assign irq      = irq_r;
    assign isr_addr = isr_addr_r;
    assign src_id   = src_id_r;

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: directed scenarios followed by randomized traffic,
// checked against a behavioural reference model of the controller.
module tb_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  done = 4'h0;
    logic        we = 1'b0;
    logic [1:0]  a = 2'd0;
    logic [31:0] wd = 32'h0;
    logic [31:0] rd;
    logic        iack = 1'b0;
    logic        irq;
    logic [31:0] isr_addr;
    logic [1:0]  src_id;

    int total = 0;
    int bad   = 0;

    irq_ctrl dut (
        .clk(clk), .rst(rst), .done(done), .we(we), .a(a), .wd(wd), .rd(rd),
        .iack(iack), .irq(irq), .isr_addr(isr_addr), .src_id(src_id)
    );

    always #5 clk = ~clk;

    // Reference model state: m_cur is the source being handled (-1 when none).
    bit [3:0] m_doneq = 4'h0;
    bit [3:0] m_pend  = 4'h0;
    bit [3:0] m_mask  = 4'h0;
    int       m_cur   = -1;
    int       m_id    = 0;
    bit       m_svc   = 1'b0;
    int       m_cnt   = 0;
    int       exp_q[$];
    bit       mon_en  = 1'b0;
    bit       irq_prev = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic m_reset();
        m_doneq = 4'h0; m_pend = 4'h0; m_mask = 4'h0;
        m_cur = -1; m_id = 0; m_svc = 1'b0; m_cnt = 0;
    endtask

    function automatic logic [31:0] m_rd(input logic [1:0] sel);
        case (sel)
            2'd0: return {28'h0, m_pend};
            2'd1: return {28'h0, m_mask};
            2'd2: return (m_svc ? 32'h8000_0000 : 32'h0) | 32'(m_id);
            default: return 32'(m_cnt);
        endcase
    endfunction

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_step();
        bit [3:0] rise;
        bit [3:0] w1c;
        bit       ack;
        if (!rst) begin
            m_reset();
            return;
        end
        rise = done & ~m_doneq;
        w1c  = (we && a == 2'd0) ? wd[3:0] : 4'h0;
        ack  = (m_cur >= 0) && !m_svc && iack;
        m_doneq = done;
        if (ack) begin
            w1c[m_cur] = 1'b1;
            if (m_cnt < 65535) m_cnt++;
        end
        if (we && a == 2'd3) m_cnt = 0;
        if (m_cur < 0) begin
            for (int i = 3; i >= 0; i--)
                if (m_pend[i] && m_mask[i]) m_cur = i;
            if (m_cur >= 0) begin
                m_id = m_cur;
                exp_q.push_back(m_cur);
            end
        end else if (!m_svc) begin
            if (ack) m_svc = 1'b1;
        end else if (we && a == 2'd2) begin
            m_cur = -1;
            m_svc = 1'b0;
        end
        m_pend = (m_pend & ~w1c) | rise;
        if (we && a == 2'd1) m_mask = wd[3:0];
    endtask

    // Monitor: compares outputs every falling edge, pops the scoreboard on each new request.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("irq", {31'h0, irq}, {31'h0, (m_cur >= 0) && !m_svc});
            chk("isr_addr", isr_addr, (m_cur >= 0) ? 32'h100 + 32'h10 * m_cur : 32'h0);
            chk("rd", rd, m_rd(a));
            if (irq && !irq_prev) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_irq", 32'h1, 32'h0);
                end else begin
                    chk("src_id", {30'h0, src_id}, 32'(exp_q.pop_front()));
                end
            end
            irq_prev = irq;
        end
    end

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        we = 1'b0;
        iack = 1'b0;
    endtask

    task automatic wr(input logic [1:0] addr, input logic [31:0] data);
        a = addr; wd = data; we = 1'b1;
        step();
    endtask

    task automatic rdchk(input string nm, input logic [1:0] addr, input logic [31:0] exp);
        a = addr;
        #1;
        chk(nm, rd, exp);
    endtask

    initial begin
        step();
        step();
        chk("reset_irq", {31'h0, irq}, 32'h0);
        chk("reset_isr", isr_addr, 32'h0);
        rdchk("reset_mask", 2'd1, 32'h0);
        rst = 1'b1;
        mon_en = 1'b1;

        // 1: single source, full handshake
        wr(2'd1, 32'hF);
        done = 4'b0100;
        step();
        rdchk("t1_pend", 2'd0, 32'h4);
        chk("t1_irq_early", {31'h0, irq}, 32'h0);
        step();
        chk("t1_irq", {31'h0, irq}, 32'h1);
        chk("t1_src", {30'h0, src_id}, 32'd2);
        chk("t1_isr", isr_addr, 32'h120);
        iack = 1'b1;
        step();
        chk("t1_irq_ack", {31'h0, irq}, 32'h0);
        rdchk("t1_pend_ack", 2'd0, 32'h0);
        rdchk("t1_count", 2'd3, 32'd1);
        rdchk("t1_active", 2'd2, 32'h8000_0002);
        wr(2'd2, 32'h0);
        chk("t1_isr_eoi", isr_addr, 32'h0);
        done = 4'b0000;
        step();

        // 2: simultaneous rises, priority then next source after EOI
        done = 4'b1010;
        step();
        step();
        chk("t2_src1", {30'h0, src_id}, 32'd1);
        chk("t2_isr1", isr_addr, 32'h110);
        iack = 1'b1;
        step();
        wr(2'd2, 32'h0);
        chk("t2_irq_eoi", {31'h0, irq}, 32'h0);
        step();
        chk("t2_irq_again", {31'h0, irq}, 32'h1);
        chk("t2_src3", {30'h0, src_id}, 32'd3);
        chk("t2_isr3", isr_addr, 32'h130);
        iack = 1'b1;
        step();
        wr(2'd2, 32'h0);
        done = 4'b0000;

        // 3: masked pending fires once unmasked
        wr(2'd1, 32'h0);
        done = 4'b0001;
        repeat (10) step();
        chk("t3_irq_masked", {31'h0, irq}, 32'h0);
        rdchk("t3_pend", 2'd0, 32'h1);
        wr(2'd1, 32'h1);
        chk("t3_irq_wait", {31'h0, irq}, 32'h0);
        step();
        chk("t3_irq", {31'h0, irq}, 32'h1);
        chk("t3_isr", isr_addr, 32'h100);
        iack = 1'b1;
        step();
        wr(2'd2, 32'h0);
        done = 4'b0000;
        step();

        // 4: set beats W1C in the same cycle
        wr(2'd1, 32'h0);
        done = 4'b0010;
        wr(2'd0, 32'h2);
        rdchk("t4_pend_set_wins", 2'd0, 32'h2);
        wr(2'd0, 32'h2);
        rdchk("t4_pend_w1c", 2'd0, 32'h0);
        done = 4'b0000;

        // 5: iack in IDLE and EOI / mask write in REQ are ignored
        iack = 1'b1;
        step();
        rdchk("t5_count_idle", 2'd3, 32'd4);
        wr(2'd1, 32'hF);
        done = 4'b0100;
        step();
        step();
        wr(2'd2, 32'h0);
        chk("t5_irq_eoi_req", {31'h0, irq}, 32'h1);
        wr(2'd1, 32'h0);
        wr(2'd0, 32'h4);
        chk("t5_irq_mask_req", {31'h0, irq}, 32'h1);
        chk("t5_src", {30'h0, src_id}, 32'd2);

        // 6: asynchronous reset in REQ
        #1;
        rst = 1'b0;
        m_reset();
        #1;
        chk("t6_irq", {31'h0, irq}, 32'h0);
        chk("t6_isr", isr_addr, 32'h0);
        rdchk("t6_pend", 2'd0, 32'h0);
        rdchk("t6_mask", 2'd1, 32'h0);
        rdchk("t6_count", 2'd3, 32'h0);
        step();
        rst = 1'b1;
        repeat (6) step();
        chk("t6_no_irq_held", {31'h0, irq}, 32'h0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = $urandom_range(0, 99);
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 7) == 0) done[b] = ~done[b];
            a = 2'($urandom_range(0, 3));
            if (r < 8) begin
                we = 1'b1; a = 2'd1; wd = $urandom;
            end else if (r < 14) begin
                we = 1'b1; a = 2'd0; wd = $urandom;
            end else if (r < 30 && m_cur >= 0 && !m_svc) begin
                iack = 1'b1;
            end else if (r < 45 && m_svc) begin
                we = 1'b1; a = 2'd2; wd = $urandom;
            end else if (r < 50) begin
                iack = 1'b1;
            end else if (r < 53) begin
                we = 1'b1; a = 2'd2; wd = $urandom;
            end
            step();
        end
        rdchk("final_count", 2'd3, 32'(m_cnt));
        @(negedge clk);
        mon_en = 1'b0;
        chk("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
